// File: rtl/bythoven_pkg.sv
// rtl/bythoven_pkg.sv - shared widths, scheduler states and event record for the note path
package bythoven_pkg;

    localparam int NOTE_W        = 4;
    localparam int OCT_W         = 2;
    localparam int FREQ_W        = 20;
    localparam int DUR_W         = 16;
    localparam int NOTE_REST_MIN = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        PLAY   = 2'd2,
        GAP    = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [OCT_W-1:0]  octave;
        logic [DUR_W-1:0]  dur;
    } note_evt_t;

    function automatic logic is_rest(input logic [NOTE_W-1:0] n);
        return n >= NOTE_W'(NOTE_REST_MIN);
    endfunction

endpackage

// File: rtl/note_fifo.sv
// rtl/note_fifo.sv - synchronous event queue with full/empty flags and flush
module note_fifo
    import bythoven_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  note_evt_t wr_data,
    input  logic      pop,
    output note_evt_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    note_evt_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - plays queued note events through the frequency calculator as a square wave
module note_scheduler
    import bythoven_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_CYCLES = 50000,
    parameter int GAP_TICKS   = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NOTE_W-1:0] in_note,
    input  logic [OCT_W-1:0]  in_octave,
    input  logic [DUR_W-1:0]  in_dur,
    input  logic              stop,
    output logic [NOTE_W-1:0] fc_note,
    output logic [OCT_W-1:0]  fc_octave,
    input  logic [FREQ_W-1:0] fc_freq,
    output logic              tone,
    output logic              busy,
    output logic              done
);

    localparam int ACC_W = $clog2(CLK_HZ) + 1;
    localparam int SUM_W = ((ACC_W > FREQ_W) ? ACC_W : FREQ_W) + 1;
    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [SUM_W-1:0] HALF = SUM_W'(CLK_HZ / 2);

    sched_state_t      state;
    note_evt_t         head;
    note_evt_t         wr_evt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DUR_W-1:0]  dur_r;
    logic [FREQ_W-1:0] freq_r;
    logic [ACC_W-1:0]  acc;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_wrap;
    logic [PRE_W-1:0]  presc;
    logic [DUR_W-1:0]  tick_cnt;
    logic [DUR_W-1:0]  tick_nxt;
    logic              presc_wrap;
    logic              play_end;
    logic              gap_end;

    assign in_ready = !full && !stop;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !empty && !stop;
    assign wr_evt   = '{note: in_note, octave: in_octave, dur: in_dur};

    note_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (stop),
        .push    (push),
        .wr_data (wr_evt),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign sum        = SUM_W'(acc) + SUM_W'(freq_r);
    assign sum_wrap   = sum - HALF;
    assign presc_wrap = (presc == PRE_W'(TICK_CYCLES - 1));
    assign tick_nxt   = tick_cnt + DUR_W'(1);
    assign play_end   = presc_wrap && (tick_nxt == dur_r);
    assign gap_end    = (GAP_TICKS == 0) || (presc_wrap && (tick_nxt == DUR_W'(GAP_TICKS)));

    // done is the last GAP cycle itself, so the next event pops right after it.
    assign done = (state == GAP) && gap_end && !stop && !rst;
    assign busy = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tone      <= 1'b0;
            acc       <= '0;
            presc     <= '0;
            tick_cnt  <= '0;
            dur_r     <= '0;
            freq_r    <= '0;
            fc_note   <= '0;
            fc_octave <= '0;
        end else if (stop) begin
            state    <= IDLE;
            tone     <= 1'b0;
            acc      <= '0;
            presc    <= '0;
            tick_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        fc_note   <= head.note;
                        fc_octave <= head.octave;
                        dur_r     <= head.dur;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    freq_r   <= fc_freq;
                    acc      <= '0;
                    presc    <= '0;
                    tick_cnt <= '0;
                    tone     <= 1'b0;
                    state    <= (dur_r == '0) ? GAP : PLAY;
                end
                PLAY: begin
                    if (play_end) begin
                        state    <= GAP;
                        tone     <= 1'b0;
                        acc      <= '0;
                        presc    <= '0;
                        tick_cnt <= '0;
                    end else begin
                        presc <= presc_wrap ? '0 : presc + PRE_W'(1);
                        if (presc_wrap) tick_cnt <= tick_nxt;
                        if (is_rest(fc_note)) begin
                            tone <= 1'b0;
                            acc  <= '0;
                        end else if (sum >= HALF) begin
                            acc  <= ACC_W'(sum_wrap);
                            tone <= ~tone;
                        end else begin
                            acc <= ACC_W'(sum);
                        end
                    end
                end
                GAP: begin
                    tone <= 1'b0;
                    acc  <= '0;
                    if (gap_end) begin
                        state    <= IDLE;
                        presc    <= '0;
                        tick_cnt <= '0;
                    end else begin
                        presc <= presc_wrap ? '0 : presc + PRE_W'(1);
                        if (presc_wrap) tick_cnt <= tick_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - directed bench for note_scheduler with a table-driven event sweep
module tb_note_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_note;
    logic [1:0]  in_octave;
    logic [15:0] in_dur;
    logic        stop;
    logic [3:0]  fc_note;
    logic [1:0]  fc_octave;
    logic [19:0] fc_freq;
    logic        tone;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    note_scheduler #(
        .CLK_HZ      (4400),
        .TICK_CYCLES (10),
        .GAP_TICKS   (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_note   (in_note),
        .in_octave (in_octave),
        .in_dur    (in_dur),
        .stop      (stop),
        .fc_note   (fc_note),
        .fc_octave (fc_octave),
        .fc_freq   (fc_freq),
        .tone      (tone),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [19:0] calc_freq(input logic [3:0] n, input logic [1:0] o);
        logic [19:0] b;
        case (n)
            4'd0:    b = 20'd131;
            4'd1:    b = 20'd139;
            4'd2:    b = 20'd147;
            4'd3:    b = 20'd156;
            4'd4:    b = 20'd165;
            4'd5:    b = 20'd175;
            4'd6:    b = 20'd185;
            4'd7:    b = 20'd196;
            4'd8:    b = 20'd208;
            4'd9:    b = 20'd220;
            4'd10:   b = 20'd233;
            4'd11:   b = 20'd247;
            default: b = 20'd0;
        endcase
        return b << o;
    endfunction

    assign fc_freq = calc_freq(fc_note, fc_octave);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_evt(input logic [3:0] n, input logic [1:0] o, input logic [15:0] d);
        in_valid  = 1'b1;
        in_note   = n;
        in_octave = o;
        in_dur    = d;
        step();
        in_valid  = 1'b0;
    endtask

    // Push one event from idle; count tone edges and locate the done pulse in edges after the push.
    task automatic run_event(input logic [3:0] n, input logic [1:0] o, input logic [15:0] d,
                             input int exp_tog, input int exp_k, input string tag);
        int   tog;
        int   done_k;
        int   dones;
        logic prev;
        push_evt(n, o, d);
        tog    = 0;
        done_k = -1;
        dones  = 0;
        prev   = 1'b0;
        for (int k = 1; k <= exp_k + 3; k++) begin
            step();
            if (k == 1) begin
                chk({tag, "_fc_note"}, int'(fc_note), int'(n));
                chk({tag, "_fc_octave"}, int'(fc_octave), int'(o));
            end
            if (tone !== prev) tog++;
            prev = tone;
            if (done) begin
                dones++;
                if (done_k < 0) begin
                    done_k = k;
                    chk({tag, "_tone_at_done"}, int'(tone), 0);
                    chk({tag, "_busy_at_done"}, int'(busy), 1);
                end
            end
            if (done_k > 0 && k == done_k + 1) chk({tag, "_busy_after_done"}, int'(busy), 0);
        end
        chk({tag, "_toggles"}, tog, exp_tog);
        chk({tag, "_done_cycle"}, done_k, exp_k);
        chk({tag, "_done_count"}, dones, 1);
    endtask

    typedef struct {
        logic [3:0]  note;
        logic [1:0]  oct;
        logic [15:0] dur;
        int          exp_tog;
        int          exp_k;
        string       tag;
    } vec_t;

    vec_t        vecs [7];
    int          idx;
    int          dones;
    int          ng;
    int          dones_at_6th;
    int          bad;
    logic [3:0]  got [6];
    logic [3:0]  prev_fc;
    logic        acc_now;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'd9,  2'd0, 16'd4, 4, 61, "a3_dur4"};
        vecs[1] = '{4'd9,  2'd1, 16'd2, 4, 41, "a4_dur2"};
        vecs[2] = '{4'd13, 2'd0, 16'd3, 0, 51, "rest_dur3"};
        vecs[3] = '{4'd0,  2'd0, 16'd0, 0, 21, "zero_dur"};
        vecs[4] = '{4'd9,  2'd2, 16'd1, 4, 31, "a5_dur1"};
        vecs[5] = '{4'd11, 2'd3, 16'd1, 8, 31, "b6_dur1"};
        vecs[6] = '{4'd0,  2'd0, 16'd1, 0, 31, "c3_short"};

        rst = 1'b1; in_valid = 1'b0; in_note = '0; in_octave = '0; in_dur = '0; stop = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("rst_tone", int'(tone), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fc_note", int'(fc_note), 0);
        chk("rst_fc_octave", int'(fc_octave), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 7; i++)
            run_event(vecs[i].note, vecs[i].oct, vecs[i].dur, vecs[i].exp_tog, vecs[i].exp_k, vecs[i].tag);

        // Full queue: six events offered back to back, first one long enough to fill the queue.
        idx = 0; dones = 0; ng = 0; dones_at_6th = -1; prev_fc = fc_note;
        for (int c = 0; c < 400 && (idx < 6 || busy); c++) begin
            in_valid  = (idx < 6);
            in_note   = (idx < 6) ? 4'(idx + 1) : 4'd0;
            in_octave = 2'd0;
            in_dur    = (idx == 0) ? 16'd2 : 16'd0;
            acc_now   = in_valid && in_ready;
            step();
            if (acc_now) begin
                if (idx == 4) chk("full_ready_after_5th", int'(in_ready), 0);
                if (idx == 5) dones_at_6th = dones;
                idx++;
            end
            if (done) dones++;
            if (fc_note != prev_fc) begin
                if (ng < 6) got[ng] = fc_note;
                ng++;
                prev_fc = fc_note;
            end
        end
        in_valid = 1'b0;
        chk("full_6th_waits_for_pop", dones_at_6th, 1);
        chk("full_pop_count", ng, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("full_order_%0d", i), int'(got[i]), i + 1);
        chk("full_done_count", dones, 6);

        // stop during the second of three queued notes
        push_evt(4'd2, 2'd0, 16'd2);
        push_evt(4'd4, 2'd0, 16'd2);
        push_evt(4'd7, 2'd0, 16'd2);
        for (int w = 0; w < 200 && fc_note != 4'd4; w++) step();
        chk("stop_reach_2nd", int'(fc_note), 4);
        repeat (15) step();
        stop = 1'b1;
        #1;
        chk("stop_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        stop = 1'b0;
        #1;
        chk("stop_tone", int'(tone), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_done", int'(done), 0);
        bad = 0;
        repeat (100) begin
            step();
            if (done || busy || tone || fc_note != 4'd4) bad++;
        end
        chk("stop_quiet", bad, 0);
        run_event(4'd9, 2'd1, 16'd2, 4, 41, "after_stop");

        // reset while a note plays with two more queued
        push_evt(4'd9, 2'd0, 16'd4);
        push_evt(4'd5, 2'd0, 16'd1);
        push_evt(4'd6, 2'd0, 16'd1);
        repeat (20) step();
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_tone", int'(tone), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_fc_note", int'(fc_note), 0);
        chk("mid_rst_fc_octave", int'(fc_octave), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        bad = 0;
        repeat (80) begin
            step();
            if (done || busy || tone || fc_note != 4'd0) bad++;
        end
        chk("mid_rst_queue_empty", bad, 0);
        run_event(4'd9, 2'd0, 16'd4, 4, 61, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
Sequences queued note events through the shared frequency calculator and produces the audible square-wave tone.
- Accepts (note, octave, duration) events over a valid/ready port into a small FIFO.
- Per event: drives note/octave to the frequency calculator, latches the returned frequency, then plays it for the requested duration with a phase accumulator.
- Sits between the processor's note-issue logic and the audio output pin.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz; must exceed 2*1975 (highest calculator output).
TICK_CYCLES, 50000, clock cycles per duration tick (default gives 1 ms).
GAP_TICKS, 2, silent articulation gap after each played note, in ticks.
FIFO_DEPTH, 4, event queue depth, power of two, at least 2.

Ports:
clk  in  1  system clock; the block's only clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  event offered
in_ready  out  1  queue can accept (not full and stop low)
in_note  in  4  semitone 0..11 (C..B); 12..15 = rest
in_octave  in  2  octave offset 0..3 (C3..B6)
in_dur  in  16  note length in ticks
stop  in  1  flush queue and abort current note
fc_note  out  4  note index to frequency calculator
fc_octave  out  2  octave to frequency calculator
fc_freq  in  20  calculator result, Hz, combinational from fc_note/fc_octave
tone  out  1  square-wave audio output
busy  out  1  high when not in IDLE or queue non-empty
done  out  1  one-cycle pulse when a note (including its gap) completes

Behaviour:
- Reset values: tone=0, done=0, busy=0, fc_note=0, fc_octave=0, queue empty, in_ready=1, state IDLE, accumulator and counters 0.
- Reset mid-note: silences tone on the next edge and discards all queued events.
- Handshake: push when in_valid&&in_ready. in_ready = !full && !stop. While full, a push and pop cannot coincide.
- IDLE:
  - If the queue is non-empty, pop the head and register note/octave/duration.
  - Drive fc_note/fc_octave from the popped event, then go to LOOKUP.
- LOOKUP (1 cycle):
  - Latch fc_freq into freq_r.
  - Clear the accumulator, tick prescaler and tick counter.
  - Go to PLAY.
  - fc_note/fc_octave hold their values until the next pop.
- PLAY:
  - Every cycle: sum = acc + freq_r (accumulator width clog2(CLK_HZ)+1). If sum >= CLK_HZ/2, then acc <= sum - CLK_HZ/2 and tone toggles; else acc <= sum. This yields a tone frequency equal to freq_r.
  - Rest note (>=12): tone forced to 0, and freq_r is ignored. The calculator is not queried meaningfully, but fc_note is still driven.
  - The prescaler counts 0..TICK_CYCLES-1. On wrap, the tick counter increments. When the tick counter reaches in_dur, go to GAP.
- GAP:
  - tone=0, accumulator cleared.
  - After GAP_TICKS ticks: pulse done and go to IDLE.
  - GAP_TICKS=0 means the done pulse and the return to IDLE occur on the first GAP cycle.
- Zero duration: LOOKUP goes directly to GAP; no tone edges are produced.
- End-to-end latency: an event pushed at edge t appears on fc_note at t+1 (if the block was idle) and enters PLAY at t+2.
- Back-to-back events: IDLE pops on the cycle after done with no extra bubble.
- Push on the same cycle as a pop (queue not full): both succeed, and the occupancy count is unchanged.
- stop:
  - Highest priority. On the next edge: queue emptied, state IDLE, tone=0, accumulator cleared, no done pulse.
  - Pushes are refused while stop is high.
- Tone polarity after a note ends is always 0, so each new note starts from a low level.

Decomposition:
- Package bythoven_pkg: NOTE_W=4, OCT_W=2, FREQ_W=20, DUR_W=16, NOTE_REST_MIN=12, and the state enum {IDLE, LOOKUP, PLAY, GAP}. Shared with the frequency calculator and the issue logic.
- Sub-module note_fifo: synchronous FIFO of {note, octave, dur}, parameterised by FIFO_DEPTH, with full/empty flags and sync reset.
- FSM, prescaler and accumulator live in note_scheduler.

Test Plan:
All scenarios use CLK_HZ=4400 and TICK_CYCLES=10 unless noted.
- Basic note: push note=9, oct=0, dur=4, GAP_TICKS=2 -> fc_freq=220 latched; tone toggles every 10 cycles for 40 cycles of PLAY (4 toggles); then 20 low cycles; done pulses exactly once; busy falls the cycle after done.
- Octave scaling: push note=9, oct=1, dur=2 -> freq_r=440; tone toggles every 5 cycles during 20 PLAY cycles.
- Rest and zero duration: push note=13, dur=3, then note=0, dur=0 -> tone stays 0 throughout; two done pulses, 30+20 and 20 cycles after the respective LOOKUPs.
- Full queue: push 5 events while the first is playing with FIFO_DEPTH=4 -> in_ready deasserts after the fifth accept (1 popped + 4 queued); a sixth in_valid is held off until the next pop. All events play in order, checked via the fc_note sequence.
- stop mid-note: during PLAY of the 2nd of 3 queued notes, assert stop for 1 cycle -> next cycle tone=0, busy=0, no done pulse; no further fc_note changes; a new push afterwards plays normally.
- Reset mid-note: assert rst during PLAY -> all outputs at their reset values the next cycle, in_ready=1, and the queue is empty (no stale note plays after release).
